// File: rtl/jtkcpu_stack_seq_pkg.sv
// jtkcpu_stack_seq_pkg: state encoding and default KCPU register slot layout
// shared by the stack sequencer and its priority encoder.
package jtkcpu_stack_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Postbyte bit order of the KCPU stack instructions
    typedef enum logic [2:0] {
        SLOT_CC = 3'd0,
        SLOT_A  = 3'd1,
        SLOT_B  = 3'd2,
        SLOT_DP = 3'd3,
        SLOT_X  = 3'd4,
        SLOT_Y  = 3'd5,
        SLOT_US = 3'd6,
        SLOT_PC = 3'd7
    } slot_t;

    localparam int         DEF_NSLOT = 8;
    localparam logic [7:0] DEF_WIDE  = 8'hF0;

endpackage

// File: rtl/jtkcpu_prienc.sv
// jtkcpu_prienc: picks the lowest (hi=0) or highest (hi=1) set bit of req;
// returns 0 when req is empty.
module jtkcpu_prienc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic                 hi,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);

    // The scan direction flips so the last match is always the wanted end
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (hi ? req[i] : req[N-1-i]) idx = W'(hi ? i : N - 1 - i);
        end
    end

endmodule

// File: rtl/jtkcpu_stack_seq.sv
// jtkcpu_stack_seq: byte-wise push/pull engine for the KCPU stack instructions.
// Define JTKCPU_STKLIM_EN to add the sp_lim port and the sticky ovf flag.
module jtkcpu_stack_seq
    import jtkcpu_stack_seq_pkg::*;
#(
    parameter int               NSLOT = DEF_NSLOT,
    parameter logic [NSLOT-1:0] WIDE  = NSLOT'(DEF_WIDE),
    parameter int               AW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen,
    input  logic                     start,
    input  logic                     pull,
    input  logic [NSLOT-1:0]         mask,
    input  logic [AW-1:0]            sp_in,
    output logic                     busy,
    output logic                     done,
    output logic [AW-1:0]            sp_out,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [7:0]               mem_dout,
    input  logic [7:0]               mem_din,
    input  logic                     mem_ack,
    output logic [$clog2(NSLOT)-1:0] reg_sel,
    output logic                     reg_hi,
    input  logic [7:0]               reg_din,
    output logic                     reg_we,
`ifdef JTKCPU_STKLIM_EN
    output logic                     ovf,
    input  logic [AW-1:0]            sp_lim,
`endif
    output logic [7:0]               reg_dout
);
    localparam int SW = $clog2(NSLOT);

    state_t           st, st_nxt;
    logic             pull_r, second, wide, last, only, ack, blk, start_ok;
    logic [NSLOT-1:0] rem;
    logic [SW-1:0]    cur_sel, we_sel;
    logic             cur_hi, we_hi;

    jtkcpu_prienc #(.N(NSLOT)) u_prienc (
        .req (rem),
        .hi  (!pull_r),
        .idx (cur_sel)
    );

    // Pushes store low then high; pulls read them back high then low
    assign wide     = WIDE[cur_sel];
    assign cur_hi   = wide && (pull_r ^ second);
    assign last     = !wide || second;
    assign only     = (rem & ~(NSLOT'(1) << cur_sel)) == '0;
    assign ack      = mem_req && mem_ack;
    assign start_ok = st == ST_IDLE && !busy && start;

`ifdef JTKCPU_STKLIM_EN
    assign blk = st == ST_XFER && !pull_r && (sp_out - AW'(1)) < sp_lim;
`else
    assign blk = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) st <= ST_IDLE;
        else if (cen) st <= st_nxt;
    end

    // IDLE with busy set is the cycle right after start was latched
    always_comb begin
        st_nxt = st == ST_IDLE ? (busy ? (rem == '0 ? ST_DONE : ST_XFER) : ST_IDLE) :
                 st == ST_XFER ? ((blk || (ack && last && only)) ? ST_DONE : ST_XFER) :
                 ST_IDLE;
    end

    always_comb begin
        mem_req  = st == ST_XFER && !blk;
        mem_we   = mem_req && !pull_r;
        mem_addr = st == ST_XFER ? (pull_r ? sp_out : sp_out - AW'(1)) : '0;
        mem_dout = mem_we ? reg_din : 8'h00;
        reg_sel  = reg_we ? we_sel : (st == ST_XFER ? cur_sel : '0);
        reg_hi   = reg_we ? we_hi : (st == ST_XFER && cur_hi);
        done     = st == ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            pull_r   <= 1'b0;
            rem      <= '0;
            sp_out   <= '0;
            second   <= 1'b0;
            reg_we   <= 1'b0;
            reg_dout <= 8'h00;
            we_sel   <= '0;
            we_hi    <= 1'b0;
        end else if (cen) begin
            reg_we <= ack && pull_r;
            if (start_ok) begin
                busy   <= 1'b1;
                pull_r <= pull;
                rem    <= mask;
                sp_out <= sp_in;
                second <= 1'b0;
            end
            if (st == ST_DONE) busy <= 1'b0;
            if (ack) begin
                sp_out <= pull_r ? sp_out + AW'(1) : sp_out - AW'(1);
                second <= !last;
                if (last) rem[cur_sel] <= 1'b0;
                if (pull_r) begin
                    reg_dout <= mem_din;
                    we_sel   <= cur_sel;
                    we_hi    <= cur_hi;
                end
            end
        end
    end

`ifdef JTKCPU_STKLIM_EN
    always_ff @(posedge clk) begin
        if (!rst) ovf <= 1'b0;
        else if (cen) ovf <= start_ok ? 1'b0 : ovf || blk;
    end
`endif

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// tb_jtkcpu_stack_seq: directed and random push/pull operations checked against
// a transaction-level stack model; covers the stack-limit build when enabled.
module tb_jtkcpu_stack_seq;

    logic        clk = 0, rst = 0, cen = 1, start = 0, pull = 0;
    logic [7:0]  mask = 0;
    logic [15:0] sp_in = 0;
    logic        busy, done, mem_req, mem_we, reg_hi, reg_we;
    logic [15:0] sp_out, mem_addr;
    logic [7:0]  mem_dout, reg_dout, reg_din;
    logic [7:0]  mem_din = 0;
    logic        mem_ack = 0;
    logic [2:0]  reg_sel;
`ifdef JTKCPU_STKLIM_EN
    logic        ovf;
    logic [15:0] sp_lim = 0;
`endif

    logic [7:0]  regs [8][2];
    logic [7:0]  mem [65536];
    logic [7:0]  wide_map = 8'hF0;
    logic [24:0] exp_tx[$], obs_tx[$];
    logic [11:0] exp_rw[$], obs_rw[$];
    logic [15:0] exp_sp, h_addr;
    logic [7:0]  h_dout;
    logic        exp_ovf, waiting = 0;
    int          nb, last_lat, n_chk = 0, n_err = 0;
    int          wmin = 0, wmax = 0, wcnt = 0, total_wait = 0;

    always #5 clk = ~clk;

    assign reg_din = regs[reg_sel][reg_hi];

    jtkcpu_stack_seq dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .start    (start),
        .pull     (pull),
        .mask     (mask),
        .sp_in    (sp_in),
        .busy     (busy),
        .done     (done),
        .sp_out   (sp_out),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .mem_ack  (mem_ack),
        .reg_sel  (reg_sel),
        .reg_hi   (reg_hi),
        .reg_din  (reg_din),
        .reg_we   (reg_we),
`ifdef JTKCPU_STKLIM_EN
        .ovf      (ovf),
        .sp_lim   (sp_lim),
`endif
        .reg_dout (reg_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    // Expected byte traffic of one operation, from the stacking rules alone
    task automatic model(input logic p, input logic [7:0] m, input logic [15:0] s, input logic [15:0] lim);
        logic        stop;
        logic [15:0] a;
        exp_tx.delete();
        exp_rw.delete();
        exp_ovf = 0;
        exp_sp  = s;
        nb      = 0;
        stop    = 0;
        if (!p) begin
            for (int i = 7; i >= 0; i--)
                if (m[i])
                    for (int b = 0; b < (wide_map[i] ? 2 : 1); b++)
                        if (!stop) begin
                            a = exp_sp - 16'd1;
                            if (a < lim) begin
                                stop    = 1;
                                exp_ovf = 1;
                            end else begin
                                exp_sp = a;
                                nb++;
                                exp_tx.push_back({a, 1'b1, regs[i][b]});
                            end
                        end
        end else begin
            for (int i = 0; i < 8; i++)
                if (m[i])
                    for (int b = 0; b < (wide_map[i] ? 2 : 1); b++) begin
                        exp_tx.push_back({exp_sp, 1'b0, 8'h00});
                        exp_rw.push_back({3'(i), wide_map[i] && b == 0, mem[exp_sp]});
                        exp_sp++;
                        nb++;
                    end
        end
    endtask

    // Memory responder and register-write monitor, all mid-cycle
    always @(negedge clk) begin
        if (mem_req) begin
            if (waiting) begin
                chk("hold_addr", mem_addr, h_addr);
                chk("hold_dout", mem_dout, h_dout);
            end else begin
                waiting = 1;
                wcnt    = $urandom_range(wmax, wmin);
                h_addr  = mem_addr;
                h_dout  = mem_dout;
            end
            if (wcnt == 0) begin
                mem_ack = 1;
                waiting = 0;
                obs_tx.push_back({mem_addr, mem_we, mem_we ? mem_dout : 8'h00});
                if (mem_we) mem[mem_addr] = mem_dout;
                else mem_din = mem[mem_addr];
            end else begin
                mem_ack = 0;
                wcnt--;
                total_wait++;
            end
        end else begin
            mem_ack = 0;
            waiting = 0;
        end
        if (reg_we) obs_rw.push_back({reg_sel, reg_hi, reg_dout});
    end

    task automatic run_op(input logic p, input logic [7:0] m, input logic [15:0] s, input logic [15:0] lim,
                          input int wmn, input int wmx, input logic hold);
        int   cyc;
        logic seen;
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 2; b++) regs[i][b] = 8'($urandom);
        model(p, m, s, lim);
        obs_tx.delete();
        obs_rw.delete();
        total_wait = 0;
        wmin = wmn;
        wmax = wmx;
        @(negedge clk);
        start = 1;
        pull  = p;
        mask  = m;
        sp_in = s;
`ifdef JTKCPU_STKLIM_EN
        sp_lim = lim;
`endif
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_set", busy, 1);
            if (hold && cyc == 1) begin
                pull  = ~p;
                mask  = ~m;
                sp_in = ~s;
            end
            if (cyc >= (hold ? 2 : 1)) start = 0;
            if (done) begin
                seen     = 1;
                last_lat = cyc;
                chk("latency", cyc, 2 + nb + total_wait + (exp_ovf ? 1 : 0));
                chk("sp_final", sp_out, exp_sp);
                chk("we_at_done", reg_we, p && nb > 0);
`ifdef JTKCPU_STKLIM_EN
                chk("ovf", ovf, exp_ovf);
`endif
            end
        end
        start = 0;
        if (!seen) chk("timeout", 0, 1);
        @(posedge clk);
        #1;
        chk("n_tx", obs_tx.size(), exp_tx.size());
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++) chk("tx", obs_tx[i], exp_tx[i]);
        chk("n_rw", obs_rw.size(), exp_rw.size());
        for (int i = 0; i < obs_rw.size() && i < exp_rw.size(); i++) chk("reg_wr", obs_rw[i], exp_rw[i]);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 2; b++) regs[i][b] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {mem_req, mem_we, reg_we}, 0);
        chk("rst_sp", sp_out, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", {mem_dout, reg_dout}, 0);
        chk("rst_sel", {reg_sel, reg_hi}, 0);
`ifdef JTKCPU_STKLIM_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1;

        run_op(0, 8'h81, 16'h1000, 16'h0000, 0, 0, 0);
        chk("push81_sp", sp_out, 16'h0FFD);
        chk("push81_lat", last_lat, 5);
        if (obs_tx.size() == 3) begin
            chk("push81_pcl", obs_tx[0], {16'h0FFF, 1'b1, regs[7][0]});
            chk("push81_pch", obs_tx[1], {16'h0FFE, 1'b1, regs[7][1]});
            chk("push81_cc", obs_tx[2], {16'h0FFD, 1'b1, regs[0][0]});
        end

        mem[16'h0FFE] = 8'h12;
        mem[16'h0FFF] = 8'h34;
        run_op(1, 8'h06, 16'h0FFE, 16'h0000, 0, 0, 0);
        chk("pull06_sp", sp_out, 16'h1000);
        if (obs_rw.size() == 2) begin
            chk("pull06_a", obs_rw[0], {3'd1, 1'b0, 8'h12});
            chk("pull06_b", obs_rw[1], {3'd2, 1'b0, 8'h34});
        end

        run_op(0, 8'h00, 16'h1234, 16'h0000, 0, 0, 0);
        chk("zero_lat", last_lat, 2);
        chk("zero_sp", sp_out, 16'h1234);

        run_op(0, 8'h10, 16'h2000, 16'h0000, 3, 3, 0);
        chk("wait_lat", last_lat, 10);

        run_op(1, 8'h80, 16'hFFFF, 16'h0000, 0, 0, 0);
        chk("wrap_sp", sp_out, 16'h0001);

        run_op(0, 8'h01, 16'h0000, 16'h0000, 0, 1, 1);
        chk("wrap_push_sp", sp_out, 16'hFFFF);

`ifdef JTKCPU_STKLIM_EN
        run_op(0, 8'h30, 16'h0103, 16'h0100, 0, 0, 0);
        chk("lim_ovf", ovf, 1);
        chk("lim_sp", sp_out, 16'h0100);
        chk("lim_bytes", obs_tx.size(), 3);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("lim_rst_ovf", ovf, 0);
        chk("lim_rst_busy", busy, 0);
        rst = 1;
`endif

        cen = 0;
        @(negedge clk);
        start = 1;
        pull  = 0;
        mask  = 8'h01;
        sp_in = 16'h0500;
        repeat (3) begin
            @(negedge clk);
            chk("cen_hold", busy, 0);
        end
        start = 0;
        cen   = 1;

        for (int k = 0; k < 40; k++) begin
            logic [15:0] s, l;
            logic [7:0]  m;
            int          r;
            r = $urandom_range(0, 3);
            s = r == 0 ? 16'($urandom_range(0, 3)) :
                r == 1 ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            l = 16'h0000;
`ifdef JTKCPU_STKLIM_EN
            if ($urandom_range(0, 2) == 0) l = s - 16'($urandom_range(0, 8));
`endif
            run_op($urandom_range(0, 1) == 1, m, s, l, 0, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        start = 1;
        pull  = 1;
        mask  = 8'hFF;
        sp_in = 16'h3000;
        wmin  = 1;
        wmax  = 1;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        rst = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_req", mem_req, 0);
        chk("abort_we", reg_we, 0);
        rst = 1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {busy, mem_req, reg_we}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
